// File: rtl/hack_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hack_loader_pkg
// Purpose  : Shared types and constants for the Hack program loader.
//            Contains the loader state enum and the byte, word and address widths.
// Revision : 1.0 - initial release
// ============================================================================
package hack_loader_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 15;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/hack_word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : hack_word_assembler
// Purpose  : Packs a big-endian byte stream into 16-bit words. The first byte
//            becomes [15:8] and the second byte becomes [7:0].
// Ports    : clk, reset     - clock and synchronous active-high reset
//            clear          - drops any half-assembled word (same priority as reset)
//            byte_valid     - byte_data is accepted this cycle
//            byte_data      - incoming byte
//            word_valid     - combinational pulse in the cycle the second byte arrives
//            word           - assembled word, meaningful while word_valid is high
// Revision : 1.0 - initial release
// ============================================================================
module hack_word_assembler
  import hack_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic              phase_q, phase_d;   // 1: high byte held, waiting for low byte
  logic [BYTE_W-1:0] hi_q, hi_d;

  always_comb begin
    phase_d    = phase_q;
    hi_d       = hi_q;
    word_valid = 1'b0;
    word       = {hi_q, byte_data};
    if (clear) begin
      phase_d = 1'b0;
    end else if (byte_valid) begin
      if (phase_q) begin
        word_valid = 1'b1;
        phase_d    = 1'b0;
      end else begin
        hi_d    = byte_data;
        phase_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= 1'b0;
      hi_q    <= '0;
    end else begin
      phase_q <= phase_d;
      hi_q    <= hi_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hack_loader.sv
`default_nettype none
// ============================================================================
// Module   : hack_loader
// Purpose  : Boot loader for the Hack CPU. Holds the CPU in reset, receives
//            length word, program words and checksum word as a byte stream,
//            writes the program to instruction memory from address 0, then
//            releases the CPU once the checksum matches.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            start                - pulse: begin or restart a load
//            rx_data/rx_valid     - byte source, rx_ready is the handshake
//            rom_we/addr/wdata    - registered instruction-memory write port
//            cpu_reset            - CPU reset, low only while running
//            done / error         - load succeeded / failed
// Revision : 1.0 - initial release
// ============================================================================
module hack_loader
  import hack_loader_pkg::*;
#(
  parameter int MAX_WORDS = 32768,
  parameter int TIMEOUT   = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [WORD_W-1:0] rom_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam int                IDLE_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit                TO_EN     = (TIMEOUT != 0);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [31:0]       MAX_N     = 32'(MAX_WORDS);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_q, last_d;     // address of the final data word (N-1)
  logic [WORD_W-1:0] sum_q, sum_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              rom_we_q, rom_we_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [WORD_W-1:0] rom_wdata_q, rom_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              load_state;
  logic              byte_accept;
  logic              word_valid;
  logic [WORD_W-1:0] word;

  assign load_state  = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CHK);
  assign rx_ready    = load_state;
  // A byte arriving together with start is dropped: start restarts from LEN.
  assign byte_accept = rx_valid && rx_ready && !start;

  hack_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (reset | start),
    .byte_valid (byte_accept),
    .byte_data  (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    last_d      = last_q;
    sum_d       = sum_q;
    idle_d      = idle_q;
    rom_we_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_wdata_d = rom_wdata_q;

    if (start) begin
      state_d = ST_LEN;
      addr_d  = '0;
      sum_d   = '0;
      idle_d  = '0;
    end else if (load_state) begin
      if (byte_accept) begin
        idle_d = '0;
      end else if (TO_EN) begin
        if (idle_q == IDLE_LAST) begin
          state_d = ST_ERR;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end

      if (word_valid) begin
        case (state_q)
          ST_LEN: begin
            if ({16'h0000, word} > MAX_N) begin
              state_d = ST_ERR;
            end else if (word == '0) begin
              state_d = ST_CHK;    // sum already cleared by start
            end else begin
              state_d = ST_DATA;
              addr_d  = '0;
              sum_d   = '0;
              last_d  = ADDR_W'(word - 16'd1);
            end
          end
          ST_DATA: begin
            rom_we_d    = 1'b1;
            rom_addr_d  = addr_q;
            rom_wdata_d = word;
            sum_d       = sum_q + word;
            addr_d      = addr_q + ADDR_W'(1);
            if (addr_q == last_q) begin
              state_d = ST_CHK;    // write still issues next cycle
            end
          end
          ST_CHK: begin
            state_d = (word == sum_q) ? ST_RUN : ST_ERR;
          end
          default: begin
          end
        endcase
      end
    end

    // Flags are registered decodes of the next state, so they change in
    // the same cycle the state register does.
    cpu_reset_d = (state_d != ST_RUN);
    done_d      = (state_d == ST_RUN);
    error_d     = (state_d == ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      last_q      <= '0;
      sum_q       <= '0;
      idle_q      <= '0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      last_q      <= last_d;
      sum_q       <= sum_d;
      idle_q      <= idle_d;
      rom_we_q    <= rom_we_d;
      rom_addr_q  <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign rom_we    = rom_we_q;
  assign rom_addr  = rom_addr_q;
  assign rom_wdata = rom_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_hack_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_hack_loader
// Purpose  : Self-checking bench for hack_loader (MAX_WORDS=32768, TIMEOUT=16).
//            Table of whole-stream vectors, hand-written corner sequences and
//            random streams compared against a stream-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hack_loader;

  localparam int MAXW = 32768;

  logic        clk = 1'b0;
  logic        reset, start, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, rom_we, cpu_reset, done, error;
  logic [14:0] rom_addr;
  logic [15:0] rom_wdata;

  always #5 clk = ~clk;

  hack_loader #(.MAX_WORDS(MAXW), .TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_wdata (rom_wdata),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Captured memory writes {addr, data}; rom_we must never be high twice in a row.
  logic [30:0] wr_q[$];
  logic [30:0] exp_wr[$];
  logic        prev_we = 1'b0;

  always @(negedge clk) begin
    if (rom_we) begin
      wr_q.push_back({rom_addr, rom_wdata});
      chk("we_spacing", 32'(prev_we), 32'd0);
    end
    prev_we = rom_we;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_stream(input logic [7:0] bs[$], input int maxgap);
    foreach (bs[i]) begin
      repeat ($urandom_range(maxgap, 0)) @(negedge clk);
      send_byte(bs[i]);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Reference: interpret the whole stream by the loader's rules.
  task automatic model(input logic [7:0] bs[$], output logic e_done, output logic e_err);
    int n, sum, w, c;
    exp_wr.delete();
    n = int'({bs[0], bs[1]});
    if (n > MAXW) begin
      e_done = 1'b0;
      e_err  = 1'b1;
      return;
    end
    sum = 0;
    for (int i = 0; i < n; i++) begin
      w   = int'({bs[2 + 2*i], bs[3 + 2*i]});
      sum = (sum + w) % 65536;
      exp_wr.push_back({15'(i), 16'(w)});
    end
    c      = int'({bs[2 + 2*n], bs[3 + 2*n]});
    e_done = (c == sum);
    e_err  = !e_done;
  endtask

  task automatic compare_writes(input string name);
    chk({name, ".nwr"}, 32'(wr_q.size()), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++)
      chk({name, ".wr"}, 32'(wr_q[i]), 32'(exp_wr[i]));
  endtask

  task automatic run_load(input string name, input logic [7:0] bs[$], input int maxgap,
                          input logic e_done, input logic e_err);
    wr_q.delete();
    pulse_start();
    send_stream(bs, maxgap);
    tick();
    tick();
    chk({name, ".done"},      32'(done),      32'(e_done));
    chk({name, ".error"},     32'(error),     32'(e_err));
    chk({name, ".cpu_reset"}, 32'(cpu_reset), 32'(!e_done));
    compare_writes(name);
  endtask

  typedef struct {
    logic [95:0] bytes;   // first byte in [95:88]
    int          nb;
    logic        e_done;
    logic        e_err;
    int          e_nwr;
  } vec_t;

  vec_t       tbl[6];
  logic [7:0] bs[$];
  logic [7:0] nominal[$];
  logic       md, me;

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    nominal  = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hBE, 8'h02};

    tbl[0] = '{96'h0003_1234_ABCD_0001_BE02_0000, 10, 1'b1, 1'b0, 3};  // nominal
    tbl[1] = '{96'h0003_1234_ABCD_0001_0000_0000, 10, 1'b0, 1'b1, 3};  // bad checksum
    tbl[2] = '{96'h0000_0000_0000_0000_0000_0000,  4, 1'b1, 1'b0, 0};  // length 0
    tbl[3] = '{96'h8001_0000_0000_0000_0000_0000,  2, 1'b0, 1'b1, 0};  // length > max
    tbl[4] = '{96'h0001_FFFF_FFFF_0000_0000_0000,  6, 1'b1, 1'b0, 1};  // single word
    tbl[5] = '{96'h0002_FFFF_0002_0001_0000_0000,  8, 1'b1, 1'b0, 2};  // sum wraps

    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst.cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst.rx_ready",  32'(rx_ready),  32'd0);
    chk("rst.rom_we",    32'(rom_we),    32'd0);
    chk("rst.rom_addr",  32'(rom_addr),  32'd0);
    chk("rst.rom_wdata", 32'(rom_wdata), 32'd0);
    chk("rst.done",      32'(done),      32'd0);
    chk("rst.error",     32'(error),     32'd0);

    // Nominal load with exact release timing
    wr_q.delete();
    pulse_start();
    chk("nom.rx_ready", 32'(rx_ready), 32'd1);
    for (int i = 0; i < 9; i++) send_byte(nominal[i]);
    chk("nom.cpu_reset_before", 32'(cpu_reset), 32'd1);
    send_byte(nominal[9]);
    chk("nom.cpu_reset_after", 32'(cpu_reset), 32'd0);
    chk("nom.done", 32'(done), 32'd1);
    exp_wr = '{{15'd0, 16'h1234}, {15'd1, 16'hABCD}, {15'd2, 16'h0001}};
    compare_writes("nom");

    // Start in RUN: CPU back in reset next cycle, load restarts
    pulse_start();
    chk("rerun.cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rerun.done",      32'(done),      32'd0);
    chk("rerun.rx_ready",  32'(rx_ready),  32'd1);
    wr_q.delete();
    send_stream(nominal, 0);
    tick();
    chk("rerun.done2", 32'(done), 32'd1);
    compare_writes("rerun");

    // Table-driven whole streams
    for (int t = 0; t < 6; t++) begin
      bs.delete();
      for (int i = 0; i < tbl[t].nb; i++) bs.push_back(tbl[t].bytes[95 - 8*i -: 8]);
      model(bs, md, me);
      run_load($sformatf("tbl%0d", t), bs, 1, tbl[t].e_done, tbl[t].e_err);
      chk($sformatf("tbl%0d.nwr_tbl", t), 32'(wr_q.size()), 32'(tbl[t].e_nwr));
    end

    // Abort mid-word; the byte presented with start is discarded
    wr_q.delete();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h12);
    start    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    tick();
    start    = 1'b0;
    rx_valid = 1'b0;
    send_stream(nominal, 0);
    tick();
    chk("abort.done", 32'(done), 32'd1);
    exp_wr = '{{15'd0, 16'h1234}, {15'd1, 16'hABCD}, {15'd2, 16'h0001}};
    compare_writes("abort");

    // Timeout after 16 idle cycles mid-DATA
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h12);
    send_byte(8'h34);
    repeat (15) tick();
    chk("tmo.error_early", 32'(error), 32'd0);
    tick();
    chk("tmo.error",     32'(error),     32'd1);
    chk("tmo.cpu_reset", 32'(cpu_reset), 32'd1);
    model(nominal, md, me);
    run_load("tmo.reload", nominal, 2, 1'b1, 1'b0);

    // Reset mid-DATA drops the pending write
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'hAB);
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hCD;
    tick();
    reset    = 1'b0;
    rx_valid = 1'b0;
    chk("mrst.cpu_reset", 32'(cpu_reset), 32'd1);
    chk("mrst.rx_ready",  32'(rx_ready),  32'd0);
    chk("mrst.rom_we",    32'(rom_we),    32'd0);
    chk("mrst.rom_addr",  32'(rom_addr),  32'd0);
    chk("mrst.rom_wdata", 32'(rom_wdata), 32'd0);
    chk("mrst.done",      32'(done),      32'd0);
    chk("mrst.error",     32'(error),     32'd0);

    // Random streams against the reference model
    for (int r = 0; r < 25; r++) begin
      int n, sum, w;
      bs.delete();
      n = ($urandom_range(7, 0) == 0) ? int'($urandom_range(65535, MAXW + 1))
                                      : int'($urandom_range(6, 0));
      bs.push_back(8'(n >> 8));
      bs.push_back(8'(n));
      if (n <= MAXW) begin
        sum = 0;
        for (int i = 0; i < n; i++) begin
          w   = int'($urandom_range(65535, 0));
          sum = (sum + w) % 65536;
          bs.push_back(8'(w >> 8));
          bs.push_back(8'(w));
        end
        if ($urandom_range(3, 0) == 0) sum = sum ^ int'($urandom_range(65535, 1));
        bs.push_back(8'(sum >> 8));
        bs.push_back(8'(sum));
      end
      model(bs, md, me);
      run_load($sformatf("rnd%0d", r), bs, 3, md, me);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hack_loader.md
# hack_loader

Boot/program loader that sequences the Hack CPU. Holds the CPU in reset, accepts a byte stream (length word, program words, checksum word), writes the program into instruction memory from address 0, then releases the CPU. Sits between a byte source (UART receiver or host FIFO) and the instruction-memory write port, and drives the CPU's `reset` input.

## Interface

**Parameters**
- `MAX_WORDS`, default 32768: largest accepted program length in words. Must be ≤ 32768.
- `TIMEOUT`, default 1000000: maximum idle cycles allowed between accepted bytes while loading. 0 disables the timeout.

**Ports** (name, direction, width, meaning)
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: one-cycle pulse that begins or restarts a load.
- `rx_data`, in, 8: incoming byte.
- `rx_valid`, in, 1: `rx_data` is valid.
- `rx_ready`, out, 1: loader accepts a byte this cycle.
- `rom_we`, out, 1: instruction-memory write strobe.
- `rom_addr`, out, 15: instruction-memory write address.
- `rom_wdata`, out, 16: instruction-memory write data.
- `cpu_reset`, out, 1: drives the CPU `reset` input.
- `done`, out, 1: load completed and checksum matched; CPU is running.
- `error`, out, 1: load failed.

## Operation

- **Byte transfer:** a byte is accepted when `rx_valid && rx_ready`. Words are big-endian: first byte → [15:8], second byte → [7:0].
- **States:** IDLE, LEN, DATA, CHK, RUN, ERR.
- **IDLE** (entered from reset)
  - `cpu_reset`=1, `rx_ready`=0.
  - `start` → LEN.
- **LEN**
  - `rx_ready`=1. Assembles the length word N.
  - N > `MAX_WORDS` → ERR.
  - N = 0 → CHK.
  - Otherwise → DATA; word address counter cleared to 0; 16-bit running sum cleared to 0.
- **DATA**
  - `rx_ready`=1. Each completed word W is written to the current address.
  - Running sum += W, modulo 2^16.
  - Address increments after each write.
  - After word N−1 is written → CHK.
- **CHK**
  - `rx_ready`=1. Assembles checksum word C.
  - C == running sum → RUN; otherwise → ERR.
- **RUN**
  - `cpu_reset`=0, `done`=1, `rx_ready`=0.
  - `start` → LEN, with `cpu_reset` reasserted in the same cycle as the transition.
- **ERR**
  - `cpu_reset`=1, `error`=1, `rx_ready`=0.
  - `start` → LEN.
- **`start` in LEN, DATA or CHK:** aborts the load and restarts at LEN. Byte phase, address and sum are cleared. A byte presented in the same cycle is discarded.
- **Timeout:** in LEN, DATA or CHK, if `TIMEOUT` ≠ 0 and `TIMEOUT` consecutive cycles pass without an accepted byte → ERR. The idle counter clears on every accepted byte and on entry to LEN.
- **Partial load:** memory words already written by a failed or aborted load are not cleared.

## Timing

- **Reset values:** state=IDLE, `cpu_reset`=1, `rx_ready`=0, `rom_we`=0, `rom_addr`=0, `rom_wdata`=0, `done`=0, `error`=0.
- **Write latency:** `rom_we`, `rom_addr` and `rom_wdata` are registered. `rom_we` pulses for exactly one cycle, in the cycle after the second byte of a data word is accepted. Address and data are stable during the pulse.
- **Back-to-back bytes:** one byte can be accepted every cycle. `rom_we` may therefore be high at most every second cycle.
- **Flag timing:** `done`, `error` and `cpu_reset` are registered state decodes.
  - After the last checksum byte is accepted, `cpu_reset` falls one cycle later.
  - The CPU fetches address 0 on the first cycle that `cpu_reset`=0.
- **Last data word vs. CHK:** the final data-word write occurs in the cycle after entering CHK. Both events can occur together; the write must still happen.
- **Reset priority:** `reset` overrides `start` and every other input. Reset mid-load returns to IDLE and drops any pending write.
- **Address width:** the address counter is 15 bits. N = 32768 fills addresses 0–32767 with no wrap write.

## Structure

- **Package `hack_loader_pkg`** contains:
  - the state enum;
  - the constants `WORD_W`=16, `ADDR_W`=15, `BYTE_W`=8.
- **Sub-module `hack_word_assembler`** contains:
  - the byte-phase flag and high-byte register;
  - the `word_valid` pulse and the 16-bit word output;
  - a synchronous `clear` input, driven on `start` and on reset.
- The top level holds the FSM, address counter, sum, timeout counter and write registers.

## Test plan

- **Nominal load:** reset, `start`, then bytes 00 03 12 34 AB CD 00 01 BE 02.
  - Three writes: (0,1234), (1,ABCD), (2,0001).
  - Checksum BE02 matches → `done`=1, `cpu_reset`=0.
- **Bad checksum:** same stream with checksum 00 00 → three writes, then `error`=1 and `cpu_reset` stays 1.
- **Boundary lengths:**
  - Length 0000 followed by checksum 0000 → RUN with no writes.
  - Length 8001 with `MAX_WORDS`=32768 → ERR immediately after the length word.
- **Abort mid-word:** `start` after a single data byte, then a fresh nominal stream → writes begin at address 0 with correct data. The stale byte has no effect.
- **Timeout:** with `TIMEOUT`=16, stall `rx_valid` for 16 cycles mid-DATA → ERR. A later `start` plus a full stream → RUN.
- **Reset and reload:**
  - `reset` mid-DATA → all outputs at reset values on the next cycle.
  - `start` in RUN → `cpu_reset`=1 on the next cycle and the load restarts.
